// File: rtl/nasti_arb_pkg.sv
// rtl/nasti_arb_pkg.sv - shared types and helpers for the NASTI read arbiter
package nasti_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } arb_state_t;

  localparam int NASTI_LEN_W   = 8;
  localparam int NASTI_SIZE_W  = 3;
  localparam int NASTI_BURST_W = 2;
  localparam int NASTI_RESP_W  = 2;

  // Burst-shape fields of an AR request; id/addr/user widths are
  // per-instance and are wrapped around this in the arbiter.
  typedef struct packed {
    logic [NASTI_LEN_W-1:0]   len;
    logic [NASTI_SIZE_W-1:0]  size;
    logic [NASTI_BURST_W-1:0] burst;
  } nasti_ar_ctl_t;

  // Index width for n requesters, never below 1 bit.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/nasti_read_arbiter_if.sv
// rtl/nasti_read_arbiter_if.sv - master-side AR/R bundle and shared slave port
interface nasti_read_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ID_WIDTH    = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int USER_WIDTH  = 1
);

  // requesting masters, slice i belongs to master i
  logic [NUM_MASTERS*ID_WIDTH-1:0]   m_ar_id;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_ar_addr;
  logic [NUM_MASTERS*8-1:0]          m_ar_len;
  logic [NUM_MASTERS*3-1:0]          m_ar_size;
  logic [NUM_MASTERS*2-1:0]          m_ar_burst;
  logic [NUM_MASTERS*USER_WIDTH-1:0] m_ar_user;
  logic [NUM_MASTERS-1:0]            m_ar_valid;
  logic [NUM_MASTERS-1:0]            m_ar_ready;
  logic [NUM_MASTERS*ID_WIDTH-1:0]   m_r_id;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_r_data;
  logic [NUM_MASTERS*2-1:0]          m_r_resp;
  logic [NUM_MASTERS-1:0]            m_r_last;
  logic [NUM_MASTERS*USER_WIDTH-1:0] m_r_user;
  logic [NUM_MASTERS-1:0]            m_r_valid;
  logic [NUM_MASTERS-1:0]            m_r_ready;

  // shared downstream read port
  logic [ID_WIDTH-1:0]   s_ar_id;
  logic [ADDR_WIDTH-1:0] s_ar_addr;
  logic [7:0]            s_ar_len;
  logic [2:0]            s_ar_size;
  logic [1:0]            s_ar_burst;
  logic [USER_WIDTH-1:0] s_ar_user;
  logic                  s_ar_lock;
  logic [3:0]            s_ar_cache;
  logic [2:0]            s_ar_prot;
  logic [3:0]            s_ar_qos;
  logic [3:0]            s_ar_region;
  logic                  s_ar_valid;
  logic                  s_ar_ready;
  logic [ID_WIDTH-1:0]   s_r_id;
  logic [DATA_WIDTH-1:0] s_r_data;
  logic [1:0]            s_r_resp;
  logic                  s_r_last;
  logic [USER_WIDTH-1:0] s_r_user;
  logic                  s_r_valid;
  logic                  s_r_ready;

  // slave: the arbiter itself, which is the slave of the requesting masters
  modport slave (
    input  m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_ar_user,
           m_ar_valid, m_r_ready,
    input  s_ar_ready, s_r_id, s_r_data, s_r_resp, s_r_last, s_r_user, s_r_valid,
    output m_ar_ready, m_r_id, m_r_data, m_r_resp, m_r_last, m_r_user, m_r_valid,
    output s_ar_id, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_ar_user,
           s_ar_lock, s_ar_cache, s_ar_prot, s_ar_qos, s_ar_region, s_ar_valid,
           s_r_ready
  );

  // master: the environment around the arbiter (requesters plus downstream slave)
  modport master (
    output m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_ar_user,
           m_ar_valid, m_r_ready,
    output s_ar_ready, s_r_id, s_r_data, s_r_resp, s_r_last, s_r_user, s_r_valid,
    input  m_ar_ready, m_r_id, m_r_data, m_r_resp, m_r_last, m_r_user, m_r_valid,
    input  s_ar_id, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_ar_user,
           s_ar_lock, s_ar_cache, s_ar_prot, s_ar_qos, s_ar_region, s_ar_valid,
           s_r_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  // scan ptr, ptr+1, ... wrapping at N; first requester wins
  always_comb begin
    int cand;
    cand        = 0;
    grant_oh    = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!grant_valid && req[cand]) begin
        grant_valid    = 1'b1;
        grant_oh[cand] = 1'b1;
        grant_idx      = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/nasti_read_arbiter.sv
// rtl/nasti_read_arbiter.sv - one-burst-at-a-time round-robin NASTI read arbiter
module nasti_read_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ID_WIDTH    = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int USER_WIDTH  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  nasti_read_arbiter_if.slave  bus,
  output logic                 err
);

  import nasti_arb_pkg::*;

  localparam int IDX_W = idx_width(NUM_MASTERS);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    nasti_ar_ctl_t         ctl;
    logic [USER_WIDTH-1:0] user;
  } nasti_ar_req_t;

  arb_state_t             state, state_n;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       grant;
  logic [7:0]             beat_cnt;
  nasti_ar_req_t          ar_q;
  nasti_ar_req_t          ar_sel;

  logic [NUM_MASTERS-1:0] arb_oh;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_valid;

  logic [NUM_MASTERS-1:0] m_ar_ready_c;
  logic [NUM_MASTERS-1:0] m_r_valid_c;
  logic [NUM_MASTERS-1:0] m_r_last_c;
  logic                   s_ar_valid_c;
  logic                   s_r_ready_c;
  logic                   ar_hs;
  logic                   r_hs;

  rr_arbiter #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req         (bus.m_ar_valid),
    .ptr         (rr_ptr),
    .grant_oh    (arb_oh),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // mux the winning master's AR fields ahead of the request register
  always_comb begin
    int sel;
    sel            = int'(arb_idx);
    ar_sel.id      = bus.m_ar_id[sel*ID_WIDTH +: ID_WIDTH];
    ar_sel.addr    = bus.m_ar_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
    ar_sel.ctl.len = bus.m_ar_len[sel*8 +: 8];
    ar_sel.ctl.size  = bus.m_ar_size[sel*3 +: 3];
    ar_sel.ctl.burst = bus.m_ar_burst[sel*2 +: 2];
    ar_sel.user    = bus.m_ar_user[sel*USER_WIDTH +: USER_WIDTH];
  end

  // next state and handshake/routing controls
  always_comb begin
    state_n      = state;
    m_ar_ready_c = '0;
    m_r_valid_c  = '0;
    m_r_last_c   = '0;
    s_ar_valid_c = 1'b0;
    s_r_ready_c  = 1'b0;
    case (state)
      S_IDLE: begin
        // ready is offered only where valid is already high, so a grant
        // is always a handshake; held low while reset is asserted
        if (!rst && arb_valid) begin
          m_ar_ready_c = arb_oh;
          state_n      = S_AR;
        end
      end
      S_AR: begin
        s_ar_valid_c = 1'b1;
        if (bus.s_ar_ready) state_n = S_R;
      end
      S_R: begin
        m_r_valid_c[grant] = bus.s_r_valid;
        m_r_last_c[grant]  = bus.s_r_last;
        s_r_ready_c        = bus.m_r_ready[grant];
        if (bus.s_r_valid && s_r_ready_c && bus.s_r_last) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign ar_hs = (state == S_IDLE) && arb_valid && !rst;
  assign r_hs  = (state == S_R) && bus.s_r_valid && s_r_ready_c;

  // state, grant bookkeeping and the registered AR request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      beat_cnt <= '0;
      ar_q     <= '0;
    end else begin
      state <= state_n;
      if (ar_hs) begin
        ar_q     <= ar_sel;
        grant    <= arb_idx;
        beat_cnt <= '0;
      end
      if (r_hs) begin
        beat_cnt <= beat_cnt + 8'd1;
        if (bus.s_r_last) begin
          if (grant == IDX_W'(NUM_MASTERS - 1)) rr_ptr <= '0;
          else                                  rr_ptr <= grant + 1'b1;
        end
      end
    end
  end

  // sticky protocol error: beat count vs len, id and resp checks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (r_hs) begin
      if ((bus.s_r_last && (beat_cnt != ar_q.ctl.len)) ||
          (!bus.s_r_last && (beat_cnt == ar_q.ctl.len)) ||
          (bus.s_r_id != ar_q.id) ||
          (bus.s_r_resp != 2'b00)) begin
        err <= 1'b1;
      end
    end
  end

  assign bus.m_ar_ready  = m_ar_ready_c;
  assign bus.m_r_valid   = m_r_valid_c;
  assign bus.m_r_last    = m_r_last_c;
  assign bus.m_r_id      = {NUM_MASTERS{bus.s_r_id}};
  assign bus.m_r_data    = {NUM_MASTERS{bus.s_r_data}};
  assign bus.m_r_resp    = {NUM_MASTERS{bus.s_r_resp}};
  assign bus.m_r_user    = {NUM_MASTERS{bus.s_r_user}};
  assign bus.s_r_ready   = s_r_ready_c;

  assign bus.s_ar_valid  = s_ar_valid_c;
  assign bus.s_ar_id     = ar_q.id;
  assign bus.s_ar_addr   = ar_q.addr;
  assign bus.s_ar_len    = ar_q.ctl.len;
  assign bus.s_ar_size   = ar_q.ctl.size;
  assign bus.s_ar_burst  = ar_q.ctl.burst;
  assign bus.s_ar_user   = ar_q.user;
  assign bus.s_ar_lock   = 1'b0;
  assign bus.s_ar_cache  = 4'd0;
  assign bus.s_ar_prot   = 3'd0;
  assign bus.s_ar_qos    = 4'd0;
  assign bus.s_ar_region = 4'd0;

endmodule

// File: tb/tb_nasti_read_arbiter.sv
// tb/tb_nasti_read_arbiter.sv - directed self-checking bench for nasti_read_arbiter
module tb_nasti_read_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic err;
  int   checks = 0;
  int   errors = 0;

  nasti_read_arbiter_if bus ();

  nasti_read_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .err (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    bus.m_ar_id    = '0;
    bus.m_ar_addr  = '0;
    bus.m_ar_len   = '0;
    bus.m_ar_size  = '0;
    bus.m_ar_burst = '0;
    bus.m_ar_user  = '0;
    bus.m_ar_valid = '0;
    bus.m_r_ready  = '0;
    bus.s_ar_ready = 1'b0;
    bus.s_r_id     = '0;
    bus.s_r_data   = '0;
    bus.s_r_resp   = '0;
    bus.s_r_last   = 1'b0;
    bus.s_r_user   = '0;
    bus.s_r_valid  = 1'b0;
  endtask

  task automatic set_req(input int m, input logic [1:0] id, input logic [31:0] addr,
                         input logic [7:0] len);
    bus.m_ar_id[m*2 +: 2]    = id;
    bus.m_ar_addr[m*32 +: 32] = addr;
    bus.m_ar_len[m*8 +: 8]   = len;
    bus.m_ar_size[m*3 +: 3]  = 3'd3;
    bus.m_ar_burst[m*2 +: 2] = 2'd1;
    bus.m_ar_user[m]         = 1'b0;
    bus.m_ar_valid[m]        = 1'b1;
  endtask

  task automatic clr_req(input int m);
    bus.m_ar_valid[m] = 1'b0;
  endtask

  task automatic drive_beat(input logic [1:0] id, input logic [63:0] data,
                            input logic last, input logic [1:0] resp);
    bus.s_r_id    = id;
    bus.s_r_data  = data;
    bus.s_r_last  = last;
    bus.s_r_resp  = resp;
    bus.s_r_valid = 1'b1;
  endtask

  task automatic end_beats();
    bus.s_r_valid = 1'b0;
    bus.s_r_last  = 1'b0;
    bus.s_r_resp  = 2'b00;
  endtask

  task automatic apply_reset();
    init_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // full burst with an always-ready environment; nbeats may differ from len+1
  task automatic do_burst(input int m, input logic [1:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input int nbeats,
                          input logic [1:0] rid, input logic [1:0] resp);
    int cnt;
    set_req(m, id, addr, len);
    #1;
    cnt = 0;
    while (!bus.m_ar_ready[m] && cnt < 10) begin
      tick();
      cnt++;
    end
    checks++;
    if (!bus.m_ar_ready[m]) begin
      errors++;
      $display("FAIL do_burst_grant: master %0d m_ar_ready=%b after %0d cycles, required ready", m,
               bus.m_ar_ready, cnt);
    end
    tick();
    clr_req(m);
    bus.s_ar_ready = 1'b1;
    tick();
    bus.s_ar_ready = 1'b0;
    bus.m_r_ready  = 2'b11;
    for (int b = 0; b < nbeats; b++) begin
      drive_beat(rid, 64'h5000 + 64'(b), b == nbeats - 1, resp);
      tick();
    end
    end_beats();
  endtask

  task automatic test_reset();
    init_inputs();
    rst = 1'b1;
    tick();
    bus.m_ar_valid = 2'b11;
    #1;
    checks++;
    if (bus.m_ar_ready !== 2'b00) begin
      errors++; $display("FAIL reset_ar_ready: got %b want 00", bus.m_ar_ready);
    end
    checks++;
    if (bus.s_ar_valid !== 1'b0 || bus.s_r_ready !== 1'b0) begin
      errors++; $display("FAIL reset_slave_hs: s_ar_valid=%b s_r_ready=%b want 0 0",
                         bus.s_ar_valid, bus.s_r_ready);
    end
    checks++;
    if (bus.m_r_valid !== 2'b00 || bus.m_r_last !== 2'b00) begin
      errors++; $display("FAIL reset_r_valid: m_r_valid=%b m_r_last=%b want 00 00",
                         bus.m_r_valid, bus.m_r_last);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b want 0", err);
    end
    checks++;
    if (bus.s_ar_addr !== 32'h0 || bus.s_ar_len !== 8'h0 || bus.s_ar_id !== 2'h0) begin
      errors++; $display("FAIL reset_ar_reg: addr=%h len=%h id=%h want 0 0 0",
                         bus.s_ar_addr, bus.s_ar_len, bus.s_ar_id);
    end
    checks++;
    if ({bus.s_ar_lock, bus.s_ar_cache, bus.s_ar_prot, bus.s_ar_qos, bus.s_ar_region} !== 16'h0) begin
      errors++; $display("FAIL reset_ar_const: got %h want 0",
                         {bus.s_ar_lock, bus.s_ar_cache, bus.s_ar_prot, bus.s_ar_qos, bus.s_ar_region});
    end
    bus.m_ar_valid = 2'b00;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [1:0] exp_last;
    set_req(0, 2'd1, 32'h100, 8'd3);
    #1;
    checks++;
    if (bus.m_ar_ready !== 2'b01) begin
      errors++; $display("FAIL single_grant: m_ar_ready=%b want 01", bus.m_ar_ready);
    end
    tick();
    clr_req(0);
    #1;
    checks++;
    if (bus.s_ar_valid !== 1'b1 || bus.s_ar_addr !== 32'h100 || bus.s_ar_len !== 8'd3 ||
        bus.s_ar_id !== 2'd1) begin
      errors++; $display("FAIL single_ar: valid=%b addr=%h len=%0d id=%0d want 1 100 3 1",
                         bus.s_ar_valid, bus.s_ar_addr, bus.s_ar_len, bus.s_ar_id);
    end
    checks++;
    if (bus.m_ar_ready !== 2'b00) begin
      errors++; $display("FAIL single_ar_ready_low: m_ar_ready=%b want 00", bus.m_ar_ready);
    end
    bus.s_ar_ready = 1'b1;
    tick();
    bus.s_ar_ready = 1'b0;
    bus.m_r_ready  = 2'b11;
    for (int b = 0; b < 4; b++) begin
      drive_beat(2'd1, 64'hA0 + 64'(b), b == 3, 2'b00);
      #1;
      exp_last = (b == 3) ? 2'b01 : 2'b00;
      checks++;
      if (bus.m_r_valid !== 2'b01 || bus.m_r_last !== exp_last ||
          bus.m_r_data[63:0] !== 64'hA0 + 64'(b) || bus.s_r_ready !== 1'b1) begin
        errors++; $display("FAIL single_beat%0d: valid=%b last=%b data=%h rdy=%b want 01 %b %h 1",
                           b, bus.m_r_valid, bus.m_r_last, bus.m_r_data[63:0], bus.s_r_ready,
                           exp_last, 64'hA0 + 64'(b));
      end
      tick();
    end
    end_beats();
    #1;
    checks++;
    if (bus.s_r_ready !== 1'b0 || bus.s_ar_valid !== 1'b0) begin
      errors++; $display("FAIL single_idle: s_r_ready=%b s_ar_valid=%b want 0 0",
                         bus.s_r_ready, bus.s_ar_valid);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL single_err: got %b want 0", err);
    end
  endtask

  task automatic test_round_robin();
    int         exp_g [4] = '{0, 1, 0, 1};
    logic [1:0] exp_oh;
    logic [1:0] exp_id;
    apply_reset();
    set_req(0, 2'd2, 32'h1000, 8'd0);
    set_req(1, 2'd3, 32'h2000, 8'd0);
    bus.m_r_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_oh = 2'(1 << exp_g[i]);
      exp_id = (exp_g[i] == 1) ? 2'd3 : 2'd2;
      #1;
      checks++;
      if (bus.m_ar_ready !== exp_oh) begin
        errors++; $display("FAIL rr_grant%0d: m_ar_ready=%b want %b", i, bus.m_ar_ready, exp_oh);
      end
      tick();
      #1;
      checks++;
      if (bus.m_ar_ready !== 2'b00 || bus.s_ar_id !== exp_id) begin
        errors++; $display("FAIL rr_ar%0d: m_ar_ready=%b s_ar_id=%0d want 00 %0d",
                           i, bus.m_ar_ready, bus.s_ar_id, exp_id);
      end
      bus.s_ar_ready = 1'b1;
      tick();
      bus.s_ar_ready = 1'b0;
      drive_beat(exp_id, 64'hD0 + 64'(i), 1'b1, 2'b00);
      #1;
      checks++;
      if (bus.m_r_valid !== exp_oh) begin
        errors++; $display("FAIL rr_beat%0d: m_r_valid=%b want %b", i, bus.m_r_valid, exp_oh);
      end
      tick();
      end_beats();
    end
    clr_req(0);
    clr_req(1);
  endtask

  task automatic test_stall_backpressure();
    int idx;
    int bad;
    int cyc;
    set_req(1, 2'd3, 32'h2000, 8'd3);
    #1;
    checks++;
    if (bus.m_ar_ready !== 2'b10) begin
      errors++; $display("FAIL bp_grant: m_ar_ready=%b want 10", bus.m_ar_ready);
    end
    tick();
    clr_req(1);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (bus.s_ar_valid !== 1'b1 || bus.s_ar_addr !== 32'h2000 || bus.s_ar_len !== 8'd3 ||
          bus.s_ar_id !== 2'd3) begin
        errors++; $display("FAIL bp_ar_stable%0d: valid=%b addr=%h len=%0d id=%0d want 1 2000 3 3",
                           c, bus.s_ar_valid, bus.s_ar_addr, bus.s_ar_len, bus.s_ar_id);
      end
      tick();
    end
    bus.s_ar_ready = 1'b1;
    tick();
    bus.s_ar_ready = 1'b0;
    idx = 0;
    bad = 0;
    cyc = 0;
    while (idx < 4 && cyc < 20) begin
      drive_beat(2'd3, 64'hB0 + 64'(idx), idx == 3, 2'b00);
      bus.m_r_ready = {(cyc < 2 || cyc > 4), 1'b1};
      #1;
      checks++;
      if (bus.s_r_ready !== bus.m_r_ready[1] || bus.m_r_valid !== 2'b10) begin
        errors++; $display("FAIL bp_route_c%0d: s_r_ready=%b m_r_valid=%b want %b 10",
                           cyc, bus.s_r_ready, bus.m_r_valid, bus.m_r_ready[1]);
      end
      if (bus.s_r_ready === 1'b1) begin
        if (bus.m_r_data[127:64] !== 64'hB0 + 64'(idx)) bad++;
        idx++;
      end
      tick();
      cyc++;
    end
    end_beats();
    #1;
    checks++;
    if (idx !== 4 || bad !== 0) begin
      errors++; $display("FAIL bp_beats: beats=%0d bad_data=%0d want 4 0", idx, bad);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL bp_err: got %b want 0", err);
    end
  endtask

  task automatic test_len_error();
    set_req(0, 2'd0, 32'h300, 8'd1);
    #1;
    checks++;
    if (bus.m_ar_ready !== 2'b01) begin
      errors++; $display("FAIL lenerr_grant: m_ar_ready=%b want 01", bus.m_ar_ready);
    end
    tick();
    clr_req(0);
    bus.s_ar_ready = 1'b1;
    tick();
    bus.s_ar_ready = 1'b0;
    bus.m_r_ready  = 2'b11;
    drive_beat(2'd0, 64'hC0, 1'b1, 2'b00);
    #1;
    checks++;
    if (err !== 1'b0 || bus.m_r_last !== 2'b01) begin
      errors++; $display("FAIL lenerr_pre: err=%b m_r_last=%b want 0 01", err, bus.m_r_last);
    end
    tick();
    end_beats();
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL lenerr_set: err=%b want 1", err);
    end
    do_burst(0, 2'd0, 32'h400, 8'd1, 2, 2'd0, 2'b00);
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL lenerr_sticky: err=%b want 1", err);
    end
    set_req(1, 2'd1, 32'h480, 8'd0);
    #1;
    checks++;
    if (bus.m_ar_ready !== 2'b10) begin
      errors++; $display("FAIL lenerr_next: m_ar_ready=%b want 10", bus.m_ar_ready);
    end
    clr_req(1);
  endtask

  task automatic test_other_errors();
    apply_reset();
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL reset_clears_err: err=%b want 0", err);
    end
    do_burst(0, 2'd1, 32'h10, 8'd0, 1, 2'd1, 2'b10);
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL resp_err: err=%b want 1", err);
    end
    apply_reset();
    do_burst(0, 2'd1, 32'h20, 8'd0, 1, 2'd2, 2'b00);
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL id_err: err=%b want 1", err);
    end
    apply_reset();
    do_burst(1, 2'd2, 32'h30, 8'd0, 2, 2'd2, 2'b00);
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL late_last_err: err=%b want 1", err);
    end
    apply_reset();
    do_burst(0, 2'd1, 32'h40, 8'd2, 3, 2'd1, 2'b00);
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL clean_burst_err: err=%b want 0", err);
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    do_burst(0, 2'd1, 32'h500, 8'd0, 1, 2'd1, 2'b00);
    set_req(1, 2'd3, 32'h600, 8'd3);
    #1;
    checks++;
    if (bus.m_ar_ready !== 2'b10) begin
      errors++; $display("FAIL mid_grant: m_ar_ready=%b want 10", bus.m_ar_ready);
    end
    tick();
    clr_req(1);
    bus.s_ar_ready = 1'b1;
    tick();
    bus.s_ar_ready = 1'b0;
    bus.m_r_ready  = 2'b11;
    for (int b = 0; b < 2; b++) begin
      drive_beat(2'd3, 64'hE0 + 64'(b), 1'b0, 2'b00);
      tick();
    end
    drive_beat(2'd3, 64'hE2, 1'b0, 2'b00);
    #1;
    checks++;
    if (bus.m_r_valid !== 2'b10) begin
      errors++; $display("FAIL mid_pre: m_r_valid=%b want 10", bus.m_r_valid);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.m_r_valid !== 2'b00 || bus.s_r_ready !== 1'b0 || bus.s_ar_valid !== 1'b0 ||
        bus.s_ar_addr !== 32'h0 || err !== 1'b0 || bus.m_ar_ready !== 2'b00) begin
      errors++; $display("FAIL mid_async_reset: rv=%b srr=%b sav=%b addr=%h err=%b ar_rdy=%b want 00 0 0 0 0 00",
                         bus.m_r_valid, bus.s_r_ready, bus.s_ar_valid, bus.s_ar_addr, err,
                         bus.m_ar_ready);
    end
    end_beats();
    tick();
    rst = 1'b0;
    set_req(0, 2'd2, 32'h700, 8'd0);
    set_req(1, 2'd3, 32'h800, 8'd0);
    #1;
    checks++;
    if (bus.m_ar_ready !== 2'b01) begin
      errors++; $display("FAIL mid_regrant: m_ar_ready=%b want 01", bus.m_ar_ready);
    end
    tick();
    clr_req(0);
    clr_req(1);
    bus.s_ar_ready = 1'b1;
    tick();
    bus.s_ar_ready = 1'b0;
    drive_beat(2'd2, 64'hF0, 1'b1, 2'b00);
    tick();
    end_beats();
  endtask

  task automatic test_long_burst();
    int fwd;
    set_req(1, 2'd3, 32'h900, 8'd255);
    #1;
    checks++;
    if (bus.m_ar_ready !== 2'b10) begin
      errors++; $display("FAIL long_grant: m_ar_ready=%b want 10", bus.m_ar_ready);
    end
    tick();
    clr_req(1);
    bus.s_ar_ready = 1'b1;
    tick();
    bus.s_ar_ready = 1'b0;
    bus.m_r_ready  = 2'b11;
    fwd = 0;
    for (int b = 0; b < 256; b++) begin
      drive_beat(2'd3, 64'(b), b == 255, 2'b00);
      #1;
      if (bus.m_r_valid === 2'b10 && bus.s_r_ready === 1'b1 && bus.m_r_data[127:64] === 64'(b))
        fwd++;
      tick();
    end
    end_beats();
    #1;
    checks++;
    if (fwd !== 256) begin
      errors++; $display("FAIL long_beats: forwarded=%0d want 256", fwd);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL long_err: err=%b want 0", err);
    end
    set_req(0, 2'd0, 32'hA00, 8'd0);
    set_req(1, 2'd1, 32'hB00, 8'd0);
    #1;
    checks++;
    if (bus.m_ar_ready !== 2'b01) begin
      errors++; $display("FAIL long_ptr_adv: m_ar_ready=%b want 01", bus.m_ar_ready);
    end
    clr_req(0);
    clr_req(1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall_backpressure();
    test_len_error();
    test_other_errors();
    test_reset_mid_burst();
    test_long_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
